// File: rtl/seq_bin2bcd.sv
// Iterative double-dabble binary-to-BCD converter, one operand bit per clock, start/done handshake.
// Optional two's-complement input when SEQ_BIN2BCD_SIGNED_EN is defined (magnitude converted, sign on is_negative).
module seq_bin2bcd #(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  overflow,
   output logic                  is_negative
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

   typedef enum logic {
      S_IDLE,
      S_SHIFT
   } state_t;

   state_t            state_q, state_d;
   logic [BIN_W-1:0]  opnd_q, opnd_d;
   logic [ACC_W-1:0]  acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sticky_q, sticky_d;
   logic [ACC_W-1:0]  bcd_q, bcd_d;
   logic              ovf_q, ovf_d;
   logic              done_q, done_d;

   logic [ACC_W-1:0]  acc_adj;
   logic [ACC_W-1:0]  acc_shl;
   logic [BIN_W-1:0]  opnd_shl;
   logic              shout;
   logic [BIN_W-1:0]  load_val;

   // Per-digit +3 correction; digits are independent, no carry between them.
   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dig
         assign acc_adj[4*gi +: 4] = (acc_q[4*gi +: 4] >= 4'd5) ? (acc_q[4*gi +: 4] + 4'd3)
                                                                 : acc_q[4*gi +: 4];
      end
   endgenerate

   assign {acc_shl, opnd_shl} = {acc_adj[ACC_W-2:0], opnd_q, 1'b0};
   assign shout               = acc_adj[ACC_W-1];

`ifdef SEQ_BIN2BCD_SIGNED_EN
   logic sign_q, sign_d;
   logic neg_q, neg_d;

   // Magnitude as an unsigned BIN_W value, so the most negative input converts to 2^(BIN_W-1).
   assign load_val = bin[BIN_W-1] ? ({BIN_W{1'b0}} - bin) : bin;
`else
   assign load_val = bin;
`endif

   always_comb begin
      state_d  = state_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      bcd_d    = bcd_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
`ifdef SEQ_BIN2BCD_SIGNED_EN
      sign_d   = sign_q;
      neg_d    = neg_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               opnd_d   = load_val;
               acc_d    = '0;
               cnt_d    = '0;
               sticky_d = 1'b0;
               state_d  = S_SHIFT;
`ifdef SEQ_BIN2BCD_SIGNED_EN
               sign_d   = bin[BIN_W-1];
`endif
            end
         end
         S_SHIFT: begin
            opnd_d   = opnd_shl;
            acc_d    = acc_shl;
            sticky_d = sticky_q | shout;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               // Results are published on the last shift edge; no separate done state.
               bcd_d   = acc_shl;
               ovf_d   = sticky_q | shout;
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
`ifdef SEQ_BIN2BCD_SIGNED_EN
               neg_d   = sign_q;
`endif
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         opnd_q   <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         sticky_q <= 1'b0;
         bcd_q    <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         sticky_q <= sticky_d;
         bcd_q    <= bcd_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

`ifdef SEQ_BIN2BCD_SIGNED_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sign_q <= 1'b0;
         neg_q  <= 1'b0;
      end else begin
         sign_q <= sign_d;
         neg_q  <= neg_d;
      end
   end

   assign is_negative = neg_q;
`else
   assign is_negative = 1'b0;
`endif

   assign busy     = (state_q == S_SHIFT);
   assign done     = done_q;
   assign bcd      = bcd_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_bin2bcd.sv
// Directed bench for seq_bin2bcd: vector table on a 5-digit instance plus corner sequences
// (re-start while busy, reset mid-conversion, 4-digit overflow).
module tb_seq_bin2bcd;

   logic        clk;
   logic        rst;
   logic        start_drv;
   logic        sel;
   logic [15:0] bin;

   logic        busy0, done0, ovf0, neg0;
   logic [19:0] bcd0;
   logic        busy1, done1, ovf1, neg1;
   logic [15:0] bcd1;

   logic        start0, start1;
   logic        obs_busy, obs_done, obs_ovf, obs_neg;
   logic [19:0] obs_bcd;

   int vec_cnt = 0;
   int err_cnt = 0;

   assign start0   = start_drv & ~sel;
   assign start1   = start_drv & sel;
   assign obs_busy = sel ? busy1 : busy0;
   assign obs_done = sel ? done1 : done0;
   assign obs_ovf  = sel ? ovf1  : ovf0;
   assign obs_neg  = sel ? neg1  : neg0;
   assign obs_bcd  = sel ? {4'h0, bcd1} : bcd0;

   seq_bin2bcd #(.BIN_W(16), .DIGITS(5)) u_dut (
      .clk(clk), .rst(rst), .start(start0), .bin(bin),
      .busy(busy0), .done(done0), .bcd(bcd0), .overflow(ovf0), .is_negative(neg0)
   );

   seq_bin2bcd #(.BIN_W(16), .DIGITS(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start1), .bin(bin),
      .busy(busy1), .done(done1), .bcd(bcd1), .overflow(ovf1), .is_negative(neg1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bin;
      logic [19:0] bcd;
      logic        ovf;
      logic        neg;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Drive start for one edge from a point just after a rising edge.
   task automatic launch(input logic [15:0] b);
      bin       = b;
      start_drv = 1'b1;
      @(posedge clk);
      #1;
      start_drv = 1'b0;
   endtask

   // Wait for done, counting edges since the accepting edge; busy must stay high until then.
   task automatic wait_done(input int elapsed, input string nm);
      int cyc = elapsed;
      int lat = -1;
      while (cyc < 40 && lat < 0) begin
         @(posedge clk);
         #1;
         cyc++;
         if (obs_done) lat = cyc;
         else if (!obs_busy) begin
            lat = 1000 + cyc;
         end
      end
      chk({nm, " latency"}, lat, 16);
      chk({nm, " busy low at done"}, {31'd0, obs_busy}, 0);
   endtask

   task automatic count_done(input int cycles, output int n);
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         if (obs_done) n++;
      end
   endtask

   initial begin
      int n;
      logic [19:0] prev_bcd;

`ifdef SEQ_BIN2BCD_SIGNED_EN
      vecs[0]  = '{16'd0,     20'h00000, 1'b0, 1'b0};
      vecs[1]  = '{16'hFFFF,  20'h00001, 1'b0, 1'b1};
      vecs[2]  = '{16'd12345, 20'h12345, 1'b0, 1'b0};
      vecs[3]  = '{16'h8000,  20'h32768, 1'b0, 1'b1};
      vecs[4]  = '{16'd42,    20'h00042, 1'b0, 1'b0};
      vecs[5]  = '{16'd59999, 20'h05537, 1'b0, 1'b1};
      vecs[6]  = '{16'd99,    20'h00099, 1'b0, 1'b0};
      vecs[7]  = '{16'd100,   20'h00100, 1'b0, 1'b0};
      vecs[8]  = '{16'd9999,  20'h09999, 1'b0, 1'b0};
      vecs[9]  = '{16'h7FFF,  20'h32767, 1'b0, 1'b0};
      vecs[10] = '{16'hFFF6,  20'h00010, 1'b0, 1'b1};
      vecs[11] = '{16'd1,     20'h00001, 1'b0, 1'b0};
`else
      vecs[0]  = '{16'd0,     20'h00000, 1'b0, 1'b0};
      vecs[1]  = '{16'd65535, 20'h65535, 1'b0, 1'b0};
      vecs[2]  = '{16'd12345, 20'h12345, 1'b0, 1'b0};
      vecs[3]  = '{16'h8000,  20'h32768, 1'b0, 1'b0};
      vecs[4]  = '{16'd42,    20'h00042, 1'b0, 1'b0};
      vecs[5]  = '{16'd59999, 20'h59999, 1'b0, 1'b0};
      vecs[6]  = '{16'd99,    20'h00099, 1'b0, 1'b0};
      vecs[7]  = '{16'd100,   20'h00100, 1'b0, 1'b0};
      vecs[8]  = '{16'd9999,  20'h09999, 1'b0, 1'b0};
      vecs[9]  = '{16'h7FFF,  20'h32767, 1'b0, 1'b0};
      vecs[10] = '{16'd10,    20'h00010, 1'b0, 1'b0};
      vecs[11] = '{16'd1,     20'h00001, 1'b0, 1'b0};
`endif

      rst       = 1'b0;
      start_drv = 1'b0;
      sel       = 1'b0;
      bin       = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", {31'd0, obs_busy}, 0);
      chk("reset done", {31'd0, obs_done}, 0);
      chk("reset bcd", {12'd0, obs_bcd}, 0);
      chk("reset ovf", {31'd0, obs_ovf}, 0);
      chk("reset neg", {31'd0, obs_neg}, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Each vector is launched in the done cycle of the previous one (back-to-back).
      prev_bcd = 20'h0;
      for (int i = 0; i < 12; i++) begin
         launch(vecs[i].bin);
         chk($sformatf("v%0d busy after start", i), {31'd0, obs_busy}, 1);
         chk($sformatf("v%0d done cleared", i), {31'd0, obs_done}, 0);
         chk($sformatf("v%0d bcd held", i), {12'd0, obs_bcd}, {12'd0, prev_bcd});
         wait_done(0, $sformatf("v%0d", i));
         chk($sformatf("v%0d bcd", i), {12'd0, obs_bcd}, {12'd0, vecs[i].bcd});
         chk($sformatf("v%0d ovf", i), {31'd0, obs_ovf}, {31'd0, vecs[i].ovf});
         chk($sformatf("v%0d neg", i), {31'd0, obs_neg}, {31'd0, vecs[i].neg});
         $display("vec %0d: bin=%h bcd=%h ovf=%b neg=%b", i, vecs[i].bin, obs_bcd, obs_ovf, obs_neg);
         prev_bcd = vecs[i].bcd;
      end
      @(posedge clk);
      #1;
      chk("done one cycle", {31'd0, obs_done}, 0);
      chk("bcd held idle", {12'd0, obs_bcd}, {12'd0, prev_bcd});

      // Re-start while busy with a different operand: ignored, single done.
      launch(16'd100);
      repeat (4) @(posedge clk);
      #1;
      bin       = 16'd999;
      start_drv = 1'b1;
      @(posedge clk);
      #1;
      start_drv = 1'b0;
      chk("restart busy held", {31'd0, obs_busy}, 1);
      wait_done(5, "restart");
      chk("restart bcd", {12'd0, obs_bcd}, 32'h00100);
      count_done(20, n);
      chk("restart extra done", n, 0);
      $display("seq restart: bcd=%h extra_done=%0d", obs_bcd, n);

      // Reset mid-conversion: everything clears immediately, no done later.
      launch(16'd12345);
      repeat (7) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("abort busy", {31'd0, obs_busy}, 0);
      chk("abort done", {31'd0, obs_done}, 0);
      chk("abort bcd", {12'd0, obs_bcd}, 0);
      #3;
      rst = 1'b1;
      count_done(20, n);
      chk("abort no done", n, 0);
      chk("abort busy after", {31'd0, obs_busy}, 0);
      $display("seq abort: busy=%b bcd=%h done_seen=%0d", obs_busy, obs_bcd, n);

      // Four-digit instance: overflow keeps low digits, then clears on a fitting value.
      sel = 1'b1;
      #1;
      launch(16'd65535);
      wait_done(0, "d4 max");
`ifdef SEQ_BIN2BCD_SIGNED_EN
      chk("d4 max bcd", {12'd0, obs_bcd}, 32'h0001);
      chk("d4 max ovf", {31'd0, obs_ovf}, 0);
      chk("d4 max neg", {31'd0, obs_neg}, 1);
`else
      chk("d4 max bcd", {12'd0, obs_bcd}, 32'h5535);
      chk("d4 max ovf", {31'd0, obs_ovf}, 1);
      chk("d4 max neg", {31'd0, obs_neg}, 0);
`endif
      $display("seq d4 max: bcd=%h ovf=%b neg=%b", obs_bcd, obs_ovf, obs_neg);
      launch(16'd10000);
      wait_done(0, "d4 10000");
      chk("d4 10000 bcd", {12'd0, obs_bcd}, 32'h0000);
      chk("d4 10000 ovf", {31'd0, obs_ovf}, 1);
      $display("seq d4 10000: bcd=%h ovf=%b", obs_bcd, obs_ovf);
      launch(16'd9999);
      wait_done(0, "d4 9999");
      chk("d4 9999 bcd", {12'd0, obs_bcd}, 32'h9999);
      chk("d4 9999 ovf", {31'd0, obs_ovf}, 0);
      $display("seq d4 9999: bcd=%h ovf=%b", obs_bcd, obs_ovf);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
